mem_port_arbiter: RTL and testbench

- Shares the processor's single-port program/data memory between two requesters.
- Requester 0 is the core FSM, which fetches instructions and reads/writes cells.
- Requester 1 is a host port used for program load, debug peek/poke and I/O.
- Fixed priority to core, a bounded-starvation override for host, and a read-latency tracker that returns read data with a valid strobe.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_starve_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM states, requester IDs and legal parameter bounds.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int RD_LAT_MIN   = 1;
  localparam int RD_LAT_MAX   = 4;
  localparam int MAX_WAIT_MIN = 1;
  localparam int MAX_WAIT_MAX = 15;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating host wait counter; sat flags that the host has waited MAX_WAIT
// cycles and must win the next arbitration.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = $clog2(MAX_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the core (fixed priority) and the
// host (starvation override), and returns read data with an rvalid strobe.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t     state, state_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic       owner, owner_nxt;
  logic       host_starved, grant_core, grant_host, rd_done;

  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (host_req && !grant_host),
    .clr   (!host_req || grant_host),
    .sat   (host_starved)
  );

  // Grants only exist in IDLE; reset masks every output combinationally.
  always_comb begin
    grant_host = 1'b0;
    grant_core = 1'b0;
    if (!reset && state == ST_IDLE) begin
      grant_host = host_req && (host_starved || !core_req);
      grant_core = core_req && !grant_host;
    end
  end

  always_comb begin
    core_gnt  = grant_core;
    host_gnt  = grant_host;
    mem_en    = grant_core || grant_host;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_host) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (grant_core) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
    rd_done     = !reset && state == ST_RD_WAIT && lat_cnt == 3'd1;
    core_rvalid = rd_done && owner == REQ_CORE;
    host_rvalid = rd_done && owner == REQ_HOST;
    core_rdata  = core_rvalid ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
    busy        = !reset && state == ST_RD_WAIT;
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    owner_nxt   = owner;
    case (state)
      ST_IDLE: begin
        if (mem_en && !mem_we) begin
          state_nxt   = ST_RD_WAIT;
          lat_cnt_nxt = LAT_LOAD;
          owner_nxt   = grant_host ? REQ_HOST : REQ_CORE;
        end
      end
      ST_RD_WAIT: begin
        lat_cnt_nxt = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      lat_cnt <= 3'd0;
      owner   <= REQ_CORE;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      owner   <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=3) share one stimulus
// stream, each backed by its own behavioural memory.
module tb_mem_port_arbiter;

  typedef struct {
    logic       rst;
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       hreq;
    logic       hwe;
    logic [7:0] haddr;
    logic [7:0] hwd;
  } stim_t;

  // flags = {core_gnt, host_gnt, core_rvalid, host_rvalid, mem_en, mem_we, busy}
  typedef struct {
    logic [6:0] flags;
    logic [7:0] crd;
    logic [7:0] hrd;
    logic [7:0] maddr;
    logic [7:0] mwd;
  } want_t;

  typedef struct {
    stim_t stim;
    want_t want;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       core_req = 1'b0, core_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0, host_addr = '0, host_wdata = '0;

  logic       core_gnt_a, core_rvalid_a, host_gnt_a, host_rvalid_a, mem_en_a, mem_we_a, busy_a;
  logic [7:0] core_rdata_a, host_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic       core_gnt_b, core_rvalid_b, host_gnt_b, host_rvalid_b, mem_en_b, mem_we_b, busy_b;
  logic [7:0] core_rdata_b, host_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt_a), .core_rvalid(core_rvalid_a), .core_rdata(core_rdata_a),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_a), .host_rvalid(host_rvalid_a), .host_rdata(host_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .MAX_WAIT(4)) dut_b (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt_b), .core_rvalid(core_rvalid_b), .core_rdata(core_rdata_b),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_b), .host_rvalid(host_rvalid_b), .host_rdata(host_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  function automatic logic [7:0] preset(input logic [7:0] a);
    case (a)
      8'h05:   return 8'h2B;
      8'hFF:   return 8'hC3;
      8'h40:   return 8'h9E;
      8'h41:   return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  // Memories reload their preset contents whenever reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= preset(8'(i));
        mem_b[i] <= preset(8'(i));
      end
    end else begin
      if (mem_en_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_en_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
    pipe_a    <= mem_addr_a;
    pipe_b[0] <= mem_addr_b;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign mem_rdata_a = mem_a[pipe_a];
  assign mem_rdata_b = mem_b[pipe_b[2]];

  function automatic stim_t mk(input logic rst, input logic creq, input logic cwe,
                               input logic [7:0] caddr, input logic [7:0] cwd,
                               input logic hreq, input logic hwe,
                               input logic [7:0] haddr, input logic [7:0] hwd);
    stim_t s;
    s.rst = rst; s.creq = creq; s.cwe = cwe; s.caddr = caddr; s.cwd = cwd;
    s.hreq = hreq; s.hwe = hwe; s.haddr = haddr; s.hwd = hwd;
    return s;
  endfunction

  function automatic want_t ex(input logic [6:0] flags, input logic [7:0] crd,
                               input logic [7:0] hrd, input logic [7:0] maddr,
                               input logic [7:0] mwd);
    want_t w;
    w.flags = flags; w.crd = crd; w.hrd = hrd; w.maddr = maddr; w.mwd = mwd;
    return w;
  endfunction

  function automatic vec_t v(input stim_t s, input want_t w);
    vec_t r;
    r.stim = s;
    r.want = w;
    return r;
  endfunction

  task automatic apply_stimulus(input stim_t s);
    @(posedge clk);
    #1;
    reset      = s.rst;
    core_req   = s.creq;
    core_we    = s.cwe;
    core_addr  = s.caddr;
    core_wdata = s.cwd;
    host_req   = s.hreq;
    host_we    = s.hwe;
    host_addr  = s.haddr;
    host_wdata = s.hwd;
    @(negedge clk);
  endtask

  task automatic compare8(input string name, input string what, input logic [7:0] got,
                          input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s %s: got %h expected %h", name, what, got, want);
    end
  endtask

  task automatic check_output(input string name, input bit sel, input want_t w);
    logic [6:0] f;
    logic [7:0] crd, hrd, ma, mw;
    if (!sel) begin
      f   = {core_gnt_a, host_gnt_a, core_rvalid_a, host_rvalid_a, mem_en_a, mem_we_a, busy_a};
      crd = core_rdata_a; hrd = host_rdata_a; ma = mem_addr_a; mw = mem_wdata_a;
    end else begin
      f   = {core_gnt_b, host_gnt_b, core_rvalid_b, host_rvalid_b, mem_en_b, mem_we_b, busy_b};
      crd = core_rdata_b; hrd = host_rdata_b; ma = mem_addr_b; mw = mem_wdata_b;
    end
    checks++;
    if (f !== w.flags) begin
      failures++;
      $display("[TB] FAIL %s flags{cg,hg,crv,hrv,en,we,busy}: got %b expected %b", name, f, w.flags);
    end
    compare8(name, "core_rdata", crd, w.crd);
    compare8(name, "host_rdata", hrd, w.hrd);
    if (w.flags[2]) begin
      compare8(name, "mem_addr", ma, w.maddr);
      compare8(name, "mem_wdata", mw, w.mwd);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // RD_LAT=1 instance: reset masking, reads, priority, starvation override.
    tbl.push_back(v(mk(1,1,0,8'h05,8'h00,1,0,8'h10,8'h00), ex(7'b0000000,8'h00,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0000000,8'h00,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,1,0,8'h05,8'h00,0,0,8'h00,8'h00), ex(7'b1000100,8'h00,8'h00,8'h05,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0010001,8'h2B,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0000000,8'h00,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,1,1,8'h10,8'h7F,1,0,8'h10,8'h00), ex(7'b1000110,8'h00,8'h00,8'h10,8'h7F)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,1,0,8'h10,8'h00), ex(7'b0100100,8'h00,8'h00,8'h10,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0001001,8'h00,8'h7F,8'h00,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0000000,8'h00,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,1,1,8'h20,8'h01,1,1,8'h30,8'h55), ex(7'b1000110,8'h00,8'h00,8'h20,8'h01)));
    tbl.push_back(v(mk(0,1,1,8'h21,8'h02,1,1,8'h30,8'h55), ex(7'b1000110,8'h00,8'h00,8'h21,8'h02)));
    tbl.push_back(v(mk(0,1,1,8'h22,8'h03,1,1,8'h30,8'h55), ex(7'b1000110,8'h00,8'h00,8'h22,8'h03)));
    tbl.push_back(v(mk(0,1,1,8'h23,8'h04,1,1,8'h30,8'h55), ex(7'b1000110,8'h00,8'h00,8'h23,8'h04)));
    tbl.push_back(v(mk(0,1,1,8'h24,8'h05,1,1,8'h30,8'h55), ex(7'b0100110,8'h00,8'h00,8'h30,8'h55)));
    tbl.push_back(v(mk(0,1,1,8'h24,8'h05,1,1,8'h31,8'h66), ex(7'b1000110,8'h00,8'h00,8'h24,8'h05)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0000000,8'h00,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,1,0,8'hFF,8'h00), ex(7'b0100100,8'h00,8'h00,8'hFF,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0001001,8'h00,8'hC3,8'h00,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0000000,8'h00,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,1,0,8'h05,8'h00,0,0,8'h00,8'h00), ex(7'b1000100,8'h00,8'h00,8'h05,8'h00)));
    tbl.push_back(v(mk(0,1,0,8'h20,8'h00,0,0,8'h00,8'h00), ex(7'b0010001,8'h2B,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,1,0,8'h20,8'h00,0,0,8'h00,8'h00), ex(7'b1000100,8'h00,8'h00,8'h20,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0010001,8'h01,8'h00,8'h00,8'h00)));
    tbl.push_back(v(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00), ex(7'b0000000,8'h00,8'h00,8'h00,8'h00)));

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].stim);
      check_output($sformatf("a_vec%0d", i), 1'b0, tbl[i].want);
    end

    // RD_LAT=3: host read blocks a core request raised during RD_WAIT.
    apply_stimulus(mk(1,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    check_output("b_reset", 1'b1, ex(7'b0000000,8'h00,8'h00,8'h00,8'h00));
    apply_stimulus(mk(0,0,0,8'h00,8'h00,1,0,8'h40,8'h00));
    check_output("b_host_rd_gnt", 1'b1, ex(7'b0100100,8'h00,8'h00,8'h40,8'h00));
    apply_stimulus(mk(0,1,0,8'h41,8'h00,0,0,8'h00,8'h00));
    check_output("b_wait1", 1'b1, ex(7'b0000001,8'h00,8'h00,8'h00,8'h00));
    apply_stimulus(mk(0,1,0,8'h41,8'h00,0,0,8'h00,8'h00));
    check_output("b_wait2", 1'b1, ex(7'b0000001,8'h00,8'h00,8'h00,8'h00));
    apply_stimulus(mk(0,1,0,8'h41,8'h00,0,0,8'h00,8'h00));
    check_output("b_host_rvalid", 1'b1, ex(7'b0001001,8'h00,8'h9E,8'h00,8'h00));
    apply_stimulus(mk(0,1,0,8'h41,8'h00,0,0,8'h00,8'h00));
    check_output("b_core_gnt", 1'b1, ex(7'b1000100,8'h00,8'h00,8'h41,8'h00));
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
      check_output($sformatf("b_core_wait%0d", k), 1'b1, ex(7'b0000001,8'h00,8'h00,8'h00,8'h00));
    end
    apply_stimulus(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    check_output("b_core_rvalid", 1'b1, ex(7'b0010001,8'h3C,8'h00,8'h00,8'h00));
    apply_stimulus(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    check_output("b_idle", 1'b1, ex(7'b0000000,8'h00,8'h00,8'h00,8'h00));

    // RD_LAT=3: reset during RD_WAIT discards the pending core read.
    apply_stimulus(mk(0,1,0,8'h40,8'h00,0,0,8'h00,8'h00));
    check_output("b_rst_rd_gnt", 1'b1, ex(7'b1000100,8'h00,8'h00,8'h40,8'h00));
    apply_stimulus(mk(1,1,0,8'h40,8'h00,1,0,8'h41,8'h00));
    check_output("b_rst_mask", 1'b1, ex(7'b0000000,8'h00,8'h00,8'h00,8'h00));
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
      check_output($sformatf("b_post_rst%0d", k), 1'b1, ex(7'b0000000,8'h00,8'h00,8'h00,8'h00));
    end
    apply_stimulus(mk(0,1,0,8'h41,8'h00,0,0,8'h00,8'h00));
    check_output("b_post_rst_gnt", 1'b1, ex(7'b1000100,8'h00,8'h00,8'h41,8'h00));
    apply_stimulus(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    apply_stimulus(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    check_output("b_post_rst_busy", 1'b1, ex(7'b0000001,8'h00,8'h00,8'h00,8'h00));
    apply_stimulus(mk(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00));
    check_output("b_post_rst_rvalid", 1'b1, ex(7'b0010001,8'h3C,8'h00,8'h00,8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
